// File: rtl/lcd_panel_pkg.sv
// Shared opcodes, decoder state encoding and default panel geometry for the SPI panel responder.
package lcd_panel_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int unsigned DefaultHRes = 240;
  localparam int unsigned DefaultVRes = 160;

  typedef enum logic [1:0] {
    StIdle,
    StParam,
    StRamwr
  } panel_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises cs/dc/sclk/mosi, detects sclk rising edges and
// assembles MSB-first bytes, flagging each completed byte with the dc level seen at its last bit.
module spi_byte_rx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cs_i,
  input  logic       dc_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_dc_o
);

  logic [1:0] cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
    if (cs_sync_q[1]) begin
      // Deselect drops any partial byte.
      cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d = {shift_q[6:0], mosi_sync_q[1]};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        valid_d = 1'b1;
        data_d  = shift_d;
        dc_d    = dc_sync_q[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      dc_q        <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs_i};
      dc_sync_q   <= {dc_sync_q[0], dc_i};
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sclk_prev_q <= sclk_sync_q[1];
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign byte_dc_o    = dc_q;

endmodule

// File: rtl/lcd_spi_panel_rx.sv
// ST7789-style panel responder: decodes SWRESET/CASET/RASET/RAMWR and writes RGB332 pixels.
// Define LCD_PANEL_RX_RGB565_EN to take RGB565 (two bytes per pixel, high first) in RAMWR.
module lcd_spi_panel_rx
  import lcd_panel_pkg::*;
#(
  parameter int unsigned H_RES  = DefaultHRes,
  parameter int unsigned V_RES  = DefaultVRes,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic              lcd_cs,
  input  logic              lcd_dc,
  input  logic              lcd_sclk,
  input  logic              lcd_mosi,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              frame_done,
  output logic              win_busy
);

  localparam logic [15:0] XeReset = 16'(H_RES - 1);
  localparam logic [15:0] YeReset = 16'(V_RES - 1);
  localparam logic [15:0] HLim    = 16'(H_RES);
  localparam logic [15:0] VLim    = 16'(V_RES);

  logic       byte_valid, byte_dc;
  logic [7:0] byte_data;

  spi_byte_rx u_spi_byte_rx (
    .clk_i       (clk_25MHz),
    .rst_ni      (rst_n),
    .cs_i        (lcd_cs),
    .dc_i        (lcd_dc),
    .sclk_i      (lcd_sclk),
    .mosi_i      (lcd_mosi),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .byte_dc_o   (byte_dc)
  );

  panel_state_e      state_q, state_d;
  logic [1:0]        pcnt_q, pcnt_d;
  logic              prow_q, prow_d;
  logic [23:0]       pbuf_q, pbuf_d;
  logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]       cx_q, cx_d, cy_q, cy_d;
  logic              we_q, we_d, fd_q, fd_d, cv_q, cv_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pix_addr;
  logic [7:0]        wdata_q, wdata_d, cb_q, cb_d;
  logic [15:0]       p_start, p_end;
  logic              pix_valid;
  logic [7:0]        pix_data;
`ifdef LCD_PANEL_RX_RGB565_EN
  logic              half_q, half_d;
  logic [7:0]        hi_q, hi_d;
`endif

  assign pix_addr = ADDR_W'(cy_q) * ADDR_W'(H_RES) + ADDR_W'(cx_q);
  assign p_start  = pbuf_q[23:8];
  assign p_end    = {pbuf_q[7:0], byte_data};

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    prow_d    = prow_q;
    pbuf_d    = pbuf_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    we_d      = 1'b0;
    fd_d      = 1'b0;
    cv_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cb_d      = cb_q;
    pix_valid = 1'b0;
    pix_data  = byte_data;
`ifdef LCD_PANEL_RX_RGB565_EN
    half_d    = half_q;
    hi_d      = hi_q;
`endif
    if (byte_valid && !byte_dc) begin
      cv_d   = 1'b1;
      cb_d   = byte_data;
      pcnt_d = 2'd0;
`ifdef LCD_PANEL_RX_RGB565_EN
      half_d = 1'b0;
`endif
      case (byte_data)
        CMD_SWRESET: begin
          xs_d    = 16'd0;
          xe_d    = XeReset;
          ys_d    = 16'd0;
          ye_d    = YeReset;
          cx_d    = 16'd0;
          cy_d    = 16'd0;
          state_d = StIdle;
        end
        CMD_CASET: begin
          prow_d  = 1'b0;
          state_d = StParam;
        end
        CMD_RASET: begin
          prow_d  = 1'b1;
          state_d = StParam;
        end
        CMD_RAMWR: begin
          cx_d    = xs_q;
          cy_d    = ys_q;
          state_d = StRamwr;
        end
        default: state_d = StIdle;
      endcase
    end else if (byte_valid) begin
      case (state_q)
        StParam: begin
          if (pcnt_q == 2'd3) begin
            // An inverted range collapses to a single column/row at start.
            if (prow_q) begin
              ys_d = p_start;
              ye_d = (p_end < p_start) ? p_start : p_end;
            end else begin
              xs_d = p_start;
              xe_d = (p_end < p_start) ? p_start : p_end;
            end
            state_d = StIdle;
          end else begin
            pbuf_d = {pbuf_q[15:0], byte_data};
            pcnt_d = pcnt_q + 2'd1;
          end
        end
        StRamwr: begin
`ifdef LCD_PANEL_RX_RGB565_EN
          if (half_q) begin
            pix_valid = 1'b1;
            pix_data  = {hi_q[7:5], hi_q[2:0], byte_data[4:3]};
          end else begin
            hi_d = byte_data;
          end
          half_d = ~half_q;
`else
          pix_valid = 1'b1;
`endif
        end
        default: ;
      endcase
    end

    if (pix_valid) begin
      we_d    = (cx_q < HLim) && (cy_q < VLim);
      addr_d  = pix_addr;
      wdata_d = pix_data;
      if (cx_q == xe_q) begin
        cx_d = xs_q;
        if (cy_q == ye_q) begin
          cy_d = ys_q;
          fd_d = 1'b1;
        end else begin
          cy_d = cy_q + 16'd1;
        end
      end else begin
        cx_d = cx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= 2'd0;
      prow_q  <= 1'b0;
      pbuf_q  <= 24'h0;
      xs_q    <= 16'd0;
      xe_q    <= XeReset;
      ys_q    <= 16'd0;
      ye_q    <= YeReset;
      cx_q    <= 16'd0;
      cy_q    <= 16'd0;
      we_q    <= 1'b0;
      fd_q    <= 1'b0;
      cv_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      cb_q    <= 8'h00;
`ifdef LCD_PANEL_RX_RGB565_EN
      half_q  <= 1'b0;
      hi_q    <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      prow_q  <= prow_d;
      pbuf_q  <= pbuf_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      fd_q    <= fd_d;
      cv_q    <= cv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cb_q    <= cb_d;
`ifdef LCD_PANEL_RX_RGB565_EN
      half_q  <= half_d;
      hi_q    <= hi_d;
`endif
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_wdata   = wdata_q;
  assign cmd_valid  = cv_q;
  assign cmd_byte   = cb_q;
  assign frame_done = fd_q;
  assign win_busy   = (state_q == StRamwr);

endmodule

// File: tb/tb_lcd_spi_panel_rx.sv
// Directed bench for lcd_spi_panel_rx: drives SPI transactions and checks framebuffer writes,
// command strobes and frame_done against hand-computed values.
module tb_lcd_spi_panel_rx;

  logic        clk, rst_n, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi;
  logic        fb_we, cmd_valid, frame_done, win_busy;
  logic [15:0] fb_addr;
  logic [7:0]  fb_wdata, cmd_byte;

  lcd_spi_panel_rx dut (
    .clk_25MHz (clk),
    .rst_n     (rst_n),
    .lcd_cs    (lcd_cs),
    .lcd_dc    (lcd_dc),
    .lcd_sclk  (lcd_sclk),
    .lcd_mosi  (lcd_mosi),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .frame_done(frame_done),
    .win_busy  (win_busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          fd_cnt  = 0;
  int          cmd_cnt = 0;
  logic [15:0] fd_addr = 16'hFFFF;

  always @(negedge clk) begin
    if (fb_we) begin
      wr_addr.push_back(fb_addr);
      wr_data.push_back(fb_wdata);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (fb_we) fd_addr <= fb_addr;
    end
    if (cmd_valid) cmd_cnt <= cmd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    lcd_mosi = b;
    lcd_sclk = 1'b0;
    wait_clk(2);
    lcd_sclk = 1'b1;
    wait_clk(2);
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] v);
    lcd_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic cmd(input logic [7:0] v);
    spi_byte(1'b0, v);
  endtask

  task automatic dat(input logic [7:0] v);
    spi_byte(1'b1, v);
  endtask

  // One pixel whose RGB332 result is v, whichever input format the build uses.
  task automatic pix(input logic [7:0] v);
`ifdef LCD_PANEL_RX_RGB565_EN
    dat({v[7:5], 2'b00, v[4:2]});
    dat({3'b000, v[1:0], 3'b000});
`else
    dat(v);
`endif
  endtask

  task automatic set_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    cmd(c);
    dat(s[15:8]);
    dat(s[7:0]);
    dat(e[15:8]);
    dat(e[7:0]);
  endtask

  task automatic cs_low;
    lcd_sclk = 1'b0;
    lcd_cs   = 1'b0;
    wait_clk(3);
  endtask

  task automatic cs_high;
    lcd_sclk = 1'b0;
    wait_clk(3);
    lcd_cs = 1'b1;
    wait_clk(4);
  endtask

  task automatic settle;
    wait_clk(8);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] a,
                          input logic [7:0] d);
    check({tag, "_addr"}, (idx < wr_addr.size()) ? 32'(wr_addr[idx]) : 32'hDEAD, 32'(a));
    check({tag, "_data"}, (idx < wr_data.size()) ? 32'(wr_data[idx]) : 32'hDEAD, 32'(d));
  endtask

  int b, f, c, bad;
  logic [15:0] exp_a [8];

  initial begin
    rst_n    = 1'b0;
    lcd_cs   = 1'b1;
    lcd_dc   = 1'b0;
    lcd_sclk = 1'b0;
    lcd_mosi = 1'b0;
    wait_clk(4);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_wdata", 32'(fb_wdata), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_byte", 32'(cmd_byte), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_win_busy", 32'(win_busy), 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Full-screen default window: linear addresses, row wrap at 240.
    cs_low();
    cmd(8'h2C);
    settle();
    check("t1_cmd_byte", 32'(cmd_byte), 32'h2C);
    check("t1_win_busy", 32'(win_busy), 1);
    b = wr_addr.size();
    f = fd_cnt;
    for (int i = 0; i < 241; i++) pix(8'hA5);
    settle();
    check("t1_count", 32'(wr_addr.size() - b), 241);
    bad = 0;
    for (int i = 0; i < 241; i++)
      if (wr_addr[b+i] !== 16'(i) || wr_data[b+i] !== 8'hA5) bad++;
    check("t1_seq_errors", 32'(bad), 0);
    check("t1_no_frame_done", 32'(fd_cnt - f), 0);

    // Bottom-right 4x2 window: last pixel is address 38399.
    set_win(8'h2A, 16'd236, 16'd239);
    set_win(8'h2B, 16'd158, 16'd159);
    cmd(8'h2C);
    b = wr_addr.size();
    f = fd_cnt;
    for (int i = 0; i < 8; i++) pix(8'(i + 1));
    settle();
    exp_a = '{16'd38156, 16'd38157, 16'd38158, 16'd38159,
              16'd38396, 16'd38397, 16'd38398, 16'd38399};
    check("t1b_count", 32'(wr_addr.size() - b), 8);
    for (int i = 0; i < 8; i += 3) check_wr($sformatf("t1b_w%0d", i), b + i, exp_a[i], 8'(i + 1));
    check_wr("t1b_w7", b + 7, 16'd38399, 8'h08);
    check("t1b_fd_cnt", 32'(fd_cnt - f), 1);
    check("t1b_fd_addr", 32'(fd_addr), 32'd38399);

    // 3x2 window at (10..12, 5..6).
    set_win(8'h2A, 16'd10, 16'd12);
    set_win(8'h2B, 16'd5, 16'd6);
    cmd(8'h2C);
    b = wr_addr.size();
    f = fd_cnt;
    for (int i = 0; i < 5; i++) pix(8'h10 + 8'(i));
    settle();
    check("t2_fd_before_last", 32'(fd_cnt - f), 0);
    pix(8'h15);
    settle();
    exp_a = '{16'd1210, 16'd1211, 16'd1212, 16'd1450, 16'd1451, 16'd1452, 16'd0, 16'd0};
    check("t2_count", 32'(wr_addr.size() - b), 6);
    for (int i = 0; i < 6; i++) check_wr($sformatf("t2_w%0d", i), b + i, exp_a[i], 8'h10 + 8'(i));
    check("t2_fd_cnt", 32'(fd_cnt - f), 1);
    check("t2_fd_addr", 32'(fd_addr), 32'd1452);

    // Window straddling the right edge: x=240,241 clipped, frame_done still on 4th pixel.
    set_win(8'h2A, 16'd238, 16'd241);
    set_win(8'h2B, 16'd0, 16'd0);
    cmd(8'h2C);
    b = wr_addr.size();
    f = fd_cnt;
    for (int i = 0; i < 3; i++) pix(8'h20 + 8'(i));
    settle();
    check("t3_fd_before_last", 32'(fd_cnt - f), 0);
    pix(8'h23);
    settle();
    check("t3_count", 32'(wr_addr.size() - b), 2);
    check_wr("t3_w0", b, 16'd238, 8'h20);
    check_wr("t3_w1", b + 1, 16'd239, 8'h21);
    check("t3_fd_cnt", 32'(fd_cnt - f), 1);
    pix(8'h77);
    settle();
    check("t3_wrap_count", 32'(wr_addr.size() - b), 3);
    check_wr("t3_wrap", b + 2, 16'd238, 8'h77);
    cs_high();

    // Partial byte abandoned by cs, then a full pixel at the cursor (x=239).
    b = wr_addr.size();
    cs_low();
    lcd_dc = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_high();
    cs_low();
    pix(8'h3C);
    settle();
    check("t4_count", 32'(wr_addr.size() - b), 1);
    check_wr("t4_w0", b, 16'd239, 8'h3C);
    check("t4_win_busy", 32'(win_busy), 1);

    // SWRESET, stray data in IDLE, truncated CASET, then RAMWR on the full screen.
    cmd(8'h01);
    settle();
    check("t5_swreset_byte", 32'(cmd_byte), 32'h01);
    check("t5_swreset_idle", 32'(win_busy), 0);
    b = wr_addr.size();
    c = cmd_cnt;
    dat(8'h55);
    cmd(8'h2A);
    dat(8'h00);
    dat(8'h05);
    cmd(8'h2C);
    settle();
    check("t5_idle_data_ignored", 32'(wr_addr.size() - b), 0);
    check("t5_cmd_pulses", 32'(cmd_cnt - c), 2);
    check("t5_cmd_byte", 32'(cmd_byte), 32'h2C);
    pix(8'h42);
    pix(8'h43);
    settle();
    check_wr("t5_w0", b, 16'd0, 8'h42);
    check_wr("t5_w1", b + 1, 16'd1, 8'h43);

    // Inverted column range collapses to x=20; single-pixel window finishes at once.
    set_win(8'h2A, 16'd20, 16'd10);
    set_win(8'h2B, 16'd3, 16'd3);
    cmd(8'h2C);
    b = wr_addr.size();
    f = fd_cnt;
    pix(8'h11);
    settle();
    check_wr("t6_w0", b, 16'd740, 8'h11);
    check("t6_fd_cnt", 32'(fd_cnt - f), 1);
    check("t6_fd_addr", 32'(fd_addr), 32'd740);

`ifdef LCD_PANEL_RX_RGB565_EN
    // Pure red RGB565 reduces to 0xE0.
    cmd(8'h01);
    cmd(8'h2C);
    b = wr_addr.size();
    dat(8'hF8);
    settle();
    check("t7_half_no_write", 32'(wr_addr.size() - b), 0);
    dat(8'h00);
    settle();
    check("t7_count", 32'(wr_addr.size() - b), 1);
    check_wr("t7_w0", b, 16'd0, 8'hE0);
`endif
    cs_high();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
